// File: rtl/qsn_sched_pc5_if.sv
// Request/grant and QSN configuration bundle between requesters, scheduler and shift network.
// Master side owns requests; slave side (scheduler) drives grants, selects and completions.
interface qsn_sched_pc5_if #(
    parameter int TAG_W = 4
);
    logic [1:0]       req_valid;
    logic [2:0]       req_shift0;
    logic [2:0]       req_shift1;
    logic [TAG_W-1:0] req_tag0;
    logic [TAG_W-1:0] req_tag1;
    logic [1:0]       req_ready;
    logic             msg_load;
    logic             msg_src;
    logic [2:0]       left_sel;
    logic [2:0]       right_sel;
    logic [3:0]       merge_sel;
    logic             out_valid;
    logic [TAG_W-1:0] out_tag;
    logic             out_src;

    modport master (
        output req_valid, req_shift0, req_shift1, req_tag0, req_tag1,
        input  req_ready, msg_load, msg_src, left_sel, right_sel, merge_sel,
        input  out_valid, out_tag, out_src
    );

    modport slave (
        input  req_valid, req_shift0, req_shift1, req_tag0, req_tag1,
        output req_ready, msg_load, msg_src, left_sel, right_sel, merge_sel,
        output out_valid, out_tag, out_src
    );
endinterface

// File: rtl/qsn_sched_pc5.sv
// Round-robin scheduler for the shared Pc=5 QSN; grant is combinational, completion 3 cycles after accept.
// No downstream backpressure: one message per cycle sustained; en low only withholds new grants.
module qsn_sched_pc5 #(
    parameter int TAG_W = 4
) (
    input  logic          sys_clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          err_clr,
    output logic          err_shift,
    output logic          err_src,
    qsn_sched_pc5_if.slave bus
);
    logic [1:0]       grant;
    logic             rr;
    logic             accept;
    logic             legal;
    logic             acc_src;
    logic [2:0]       acc_shift;
    logic [TAG_W-1:0] acc_tag;
    logic             load;

    logic             s1_vld;
    logic [2:0]       s1_shift;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_src;
    logic             s2_vld;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_src;

    logic [2:0]       left_q;
    logic [2:0]       right_q;
    logic [3:0]       merge_q;
    logic             out_vld_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_src_q;

    // rr only matters on contention; a lone requester is granted directly
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (&bus.req_valid)
                grant = rr ? 2'b10 : 2'b01;
            else
                grant = bus.req_valid;
        end
    end

    assign acc_src   = grant[1];
    assign accept    = |grant;
    assign acc_shift = acc_src ? bus.req_shift1 : bus.req_shift0;
    assign acc_tag   = acc_src ? bus.req_tag1 : bus.req_tag0;
    assign legal     = (acc_shift <= 3'd4);
    assign load      = accept & legal;

    assign bus.req_ready = grant;
    assign bus.msg_load  = load;
    assign bus.msg_src   = acc_src;
    assign bus.left_sel  = left_q;
    assign bus.right_sel = right_q;
    assign bus.merge_sel = merge_q;
    assign bus.out_valid = out_vld_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_src   = out_src_q;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn)
            rr <= 1'b0;
        else if (accept)
            rr <= ~acc_src;
    end

    // Stage 1: shifter selects; held when no legal message enters
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld   <= 1'b0;
            s1_shift <= 3'd0;
            s1_tag   <= '0;
            s1_src   <= 1'b0;
            left_q   <= 3'd0;
            right_q  <= 3'd0;
        end else begin
            s1_vld <= load;
            if (load) begin
                s1_shift <= acc_shift;
                s1_tag   <= acc_tag;
                s1_src   <= acc_src;
                left_q   <= acc_shift;
                right_q  <= (acc_shift == 3'd0) ? 3'd0 : 3'd5 - acc_shift;
            end
        end
    end

    // Stage 2: merge select, tag/src travelling alongside
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            s2_vld  <= 1'b0;
            s2_tag  <= '0;
            s2_src  <= 1'b0;
            merge_q <= 4'hF;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_tag  <= s1_tag;
                s2_src  <= s1_src;
                merge_q <= 4'hF >> s1_shift;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            out_vld_q <= 1'b0;
            out_tag_q <= '0;
            out_src_q <= 1'b0;
        end else begin
            out_vld_q <= s2_vld;
            if (s2_vld) begin
                out_tag_q <= s2_tag;
                out_src_q <= s2_src;
            end
        end
    end

    // A fresh illegal shift outranks a simultaneous clear
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            err_shift <= 1'b0;
            err_src   <= 1'b0;
        end else if (accept && !legal) begin
            err_shift <= 1'b1;
            err_src   <= acc_src;
        end else if (err_clr) begin
            err_shift <= 1'b0;
        end
    end
endmodule

// File: tb/tb_qsn_sched_pc5.sv
// Bench for qsn_sched_pc5: vector table, directed corner sequences, random run against a reference model.
module tb_qsn_sched_pc5;
    localparam int TAG_W = 4;
    localparam int NRND  = 400;

    logic sys_clk;
    logic rstn;
    logic en;
    logic err_clr;
    logic err_shift;
    logic err_src;

    qsn_sched_pc5_if #(.TAG_W(TAG_W)) bus ();

    qsn_sched_pc5 #(.TAG_W(TAG_W)) dut (
        .sys_clk  (sys_clk),
        .rstn     (rstn),
        .en       (en),
        .err_clr  (err_clr),
        .err_shift(err_shift),
        .err_src  (err_src),
        .bus      (bus)
    );

    int total;
    int bad;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [1:0] v, input logic [2:0] s0, input logic [2:0] s1,
                         input logic [3:0] t0, input logic [3:0] t1, input logic clr);
        en             = e;
        bus.req_valid  = v;
        bus.req_shift0 = s0;
        bus.req_shift1 = s1;
        bus.req_tag0   = t0;
        bus.req_tag1   = t1;
        err_clr        = clr;
    endtask

    task automatic idle();
        drive(1'b1, 2'b00, 3'd0, 3'd0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        idle();
        rstn = 1'b0;
        @(negedge sys_clk);
        rstn = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, ".load"}, 32'(bus.msg_load), 32'd0);
        chk({tag, ".msrc"}, 32'(bus.msg_src), 32'd0);
        chk({tag, ".left"}, 32'(bus.left_sel), 32'd0);
        chk({tag, ".right"}, 32'(bus.right_sel), 32'd0);
        chk({tag, ".merge"}, 32'(bus.merge_sel), 32'hF);
        chk({tag, ".oval"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".otag"}, 32'(bus.out_tag), 32'd0);
        chk({tag, ".osrc"}, 32'(bus.out_src), 32'd0);
        chk({tag, ".err"}, 32'(err_shift), 32'd0);
        chk({tag, ".esrc"}, 32'(err_src), 32'd0);
    endtask

    // Merge word from its meaning: lane i comes from the left shifter while i + s stays inside the 4 lanes
    function automatic logic [3:0] merge_of(input logic [2:0] s);
        logic [3:0] m;
        m = 4'd0;
        for (int i = 0; i < 4; i++)
            if (i + int'(s) < 4) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [2:0] right_of(input logic [2:0] s);
        return 3'((5 - int'(s)) % 5);
    endfunction

    typedef struct {
        logic       e;
        logic [1:0] v;
        logic [2:0] s0;
        logic [2:0] s1;
        logic [1:0] exp_ready;
        logic       exp_load;
        logic       exp_src;
    } vec_t;

    vec_t vt[9];

    // Reference model state for the random run
    bit         acc_v  [NRND];
    logic [2:0] acc_s  [NRND];
    logic [3:0] acc_t  [NRND];
    logic       acc_src[NRND];
    logic       rr_m;
    logic       err_m;
    logic       esrc_m;

    function automatic logic [2:0] last_shift(input int upto);
        for (int k = upto; k >= 0; k--)
            if (acc_v[k]) return acc_s[k];
        return 3'd0;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        idle();

        // Each row builds on the round-robin state left by the previous one
        vt[0] = '{1'b1, 2'b01, 3'd2, 3'd0, 2'b01, 1'b1, 1'b0};
        vt[1] = '{1'b1, 2'b11, 3'd1, 3'd3, 2'b10, 1'b1, 1'b1};
        vt[2] = '{1'b1, 2'b11, 3'd1, 3'd3, 2'b01, 1'b1, 1'b0};
        vt[3] = '{1'b0, 2'b11, 3'd1, 3'd3, 2'b00, 1'b0, 1'b0};
        vt[4] = '{1'b1, 2'b10, 3'd0, 3'd6, 2'b10, 1'b0, 1'b1};
        vt[5] = '{1'b1, 2'b11, 3'd7, 3'd0, 2'b01, 1'b0, 1'b0};
        vt[6] = '{1'b1, 2'b01, 3'd4, 3'd0, 2'b01, 1'b1, 1'b0};
        vt[7] = '{1'b1, 2'b11, 3'd0, 3'd4, 2'b10, 1'b1, 1'b1};
        vt[8] = '{1'b1, 2'b00, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0};

        repeat (2) @(negedge sys_clk);
        chk_reset_vals("rst");
        rstn = 1'b1;

        // Vector table
        for (int i = 0; i < 9; i++) begin
            @(negedge sys_clk);
            drive(vt[i].e, vt[i].v, vt[i].s0, vt[i].s1, 4'(i), 4'(i + 8), 1'b0);
            #1;
            chk($sformatf("vec%0d.ready", i), 32'(bus.req_ready), 32'(vt[i].exp_ready));
            chk($sformatf("vec%0d.load", i), 32'(bus.msg_load), 32'(vt[i].exp_load));
            chk($sformatf("vec%0d.src", i), 32'(bus.msg_src), 32'(vt[i].exp_src));
        end

        // Single VNU request, s=2
        do_reset();
        @(negedge sys_clk);
        drive(1'b1, 2'b01, 3'd2, 3'd0, 4'h5, 4'h0, 1'b0);
        #1;
        chk("single.ready", 32'(bus.req_ready), 32'b01);
        chk("single.load", 32'(bus.msg_load), 32'd1);
        @(negedge sys_clk);
        idle();
        chk("single.left", 32'(bus.left_sel), 32'd2);
        chk("single.right", 32'(bus.right_sel), 32'd3);
        @(negedge sys_clk);
        chk("single.merge", 32'(bus.merge_sel), 32'b0011);
        chk("single.oval_early", 32'(bus.out_valid), 32'd0);
        @(negedge sys_clk);
        chk("single.oval", 32'(bus.out_valid), 32'd1);
        chk("single.otag", 32'(bus.out_tag), 32'h5);
        chk("single.osrc", 32'(bus.out_src), 32'd0);
        @(negedge sys_clk);
        chk("single.pulse", 32'(bus.out_valid), 32'd0);

        // Contention: both valid for 4 cycles
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge sys_clk);
            if (k >= 3 && k < 7) begin
                chk($sformatf("rr.oval%0d", k), 32'(bus.out_valid), 32'd1);
                chk($sformatf("rr.osrc%0d", k), 32'(bus.out_src), 32'((k - 3) % 2));
                chk($sformatf("rr.otag%0d", k), 32'(bus.out_tag), 32'((k - 3) + ((k - 3) % 2) * 8));
            end else if (k == 7) begin
                chk("rr.oval_end", 32'(bus.out_valid), 32'd0);
            end
            if (k < 4) drive(1'b1, 2'b11, 3'd1, 3'd1, 4'(k), 4'(k + 8), 1'b0);
            else idle();
            #1;
            if (k < 4) chk($sformatf("rr.ready%0d", k), 32'(bus.req_ready), (k % 2 == 0) ? 32'b01 : 32'b10);
        end

        // Shift sweep on requester 1, back to back
        do_reset();
        for (int k = 0; k < 7; k++) begin
            @(negedge sys_clk);
            if (k >= 1 && k <= 5) begin
                chk($sformatf("sweep.left%0d", k - 1), 32'(bus.left_sel), 32'(k - 1));
                chk($sformatf("sweep.right%0d", k - 1), 32'(bus.right_sel), 32'(right_of(3'(k - 1))));
            end
            if (k >= 2) chk($sformatf("sweep.merge%0d", k - 2), 32'(bus.merge_sel), 32'(merge_of(3'(k - 2))));
            if (k < 5) drive(1'b1, 2'b10, 3'd0, 3'(k), 4'd0, 4'(k), 1'b0);
            else idle();
        end

        // Illegal shift, then clear racing a second error
        do_reset();
        @(negedge sys_clk);
        drive(1'b1, 2'b01, 3'd6, 3'd0, 4'h3, 4'h0, 1'b0);
        #1;
        chk("ill.ready", 32'(bus.req_ready), 32'b01);
        chk("ill.load", 32'(bus.msg_load), 32'd0);
        @(negedge sys_clk);
        idle();
        chk("ill.err", 32'(err_shift), 32'd1);
        chk("ill.esrc", 32'(err_src), 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ill.nooval%0d", k), 32'(bus.out_valid), 32'd0);
            @(negedge sys_clk);
        end
        drive(1'b1, 2'b10, 3'd0, 3'd5, 4'h0, 4'h0, 1'b1);
        @(negedge sys_clk);
        drive(1'b1, 2'b00, 3'd0, 3'd0, 4'h0, 4'h0, 1'b1);
        chk("ill.setwins", 32'(err_shift), 32'd1);
        chk("ill.esrc2", 32'(err_src), 32'd1);
        @(negedge sys_clk);
        idle();
        chk("ill.cleared", 32'(err_shift), 32'd0);

        // Enable drop with an entry in flight
        do_reset();
        @(negedge sys_clk);
        drive(1'b1, 2'b01, 3'd1, 3'd0, 4'h9, 4'h0, 1'b0);
        @(negedge sys_clk);
        drive(1'b0, 2'b11, 3'd1, 3'd1, 4'h1, 4'h2, 1'b0);
        #1;
        chk("en.ready", 32'(bus.req_ready), 32'b00);
        chk("en.load", 32'(bus.msg_load), 32'd0);
        @(negedge sys_clk);
        idle();
        @(negedge sys_clk);
        chk("en.oval", 32'(bus.out_valid), 32'd1);
        chk("en.otag", 32'(bus.out_tag), 32'h9);

        // Reset mid-flight at T+1
        do_reset();
        @(negedge sys_clk);
        drive(1'b1, 2'b10, 3'd0, 3'd3, 4'h0, 4'h7, 1'b0);
        @(negedge sys_clk);
        idle();
        rstn = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge sys_clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            chk($sformatf("midrst.nooval%0d", k), 32'(bus.out_valid), 32'd0);
        end

        // Random traffic against the reference model
        do_reset();
        rr_m   = 1'b0;
        err_m  = 1'b0;
        esrc_m = 1'b0;
        for (int n = 0; n < NRND; n++) begin
            logic       e;
            logic [1:0] v;
            logic [2:0] s0;
            logic [2:0] s1;
            logic [3:0] t0;
            logic [3:0] t1;
            logic       clr;
            logic [1:0] g;
            logic       gs;
            logic [2:0] gsh;
            @(negedge sys_clk);
            chk("rnd.left", 32'(bus.left_sel), 32'(last_shift(n - 1)));
            chk("rnd.right", 32'(bus.right_sel), 32'(right_of(last_shift(n - 1))));
            chk("rnd.merge", 32'(bus.merge_sel), 32'(merge_of(last_shift(n - 2))));
            chk("rnd.oval", 32'(bus.out_valid), 32'((n >= 3) && acc_v[n >= 3 ? n - 3 : 0]));
            if (n >= 3 && acc_v[n - 3]) begin
                chk("rnd.otag", 32'(bus.out_tag), 32'(acc_t[n - 3]));
                chk("rnd.osrc", 32'(bus.out_src), 32'(acc_src[n - 3]));
            end
            chk("rnd.err", 32'(err_shift), 32'(err_m));
            if (err_m) chk("rnd.esrc", 32'(err_src), 32'(esrc_m));

            e   = ($urandom % 8) != 0;
            v   = 2'($urandom);
            s0  = ($urandom % 6 == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            s1  = ($urandom % 6 == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            t0  = 4'($urandom);
            t1  = 4'($urandom);
            clr = ($urandom % 10) == 0;
            drive(e, v, s0, s1, t0, t1, clr);
            #1;

            g  = 2'b00;
            gs = 1'b0;
            if (e && v != 2'b00) begin
                gs    = (v == 2'b11) ? rr_m : v[1];
                g[gs] = 1'b1;
                rr_m  = !gs;
            end
            gsh = gs ? s1 : s0;
            acc_v[n]   = (g != 2'b00) && (gsh < 3'd5);
            acc_s[n]   = gsh;
            acc_t[n]   = gs ? t1 : t0;
            acc_src[n] = gs;
            chk("rnd.ready", 32'(bus.req_ready), 32'(g));
            chk("rnd.load", 32'(bus.msg_load), 32'(acc_v[n]));
            if (g != 2'b00) chk("rnd.msrc", 32'(bus.msg_src), 32'(gs));

            if (g != 2'b00 && gsh >= 3'd5) begin
                err_m  = 1'b1;
                esrc_m = gs;
            end else if (clr) begin
                err_m = 1'b0;
            end
        end

        @(negedge sys_clk);
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/qsn_sched_pc5.md
# qsn_sched_pc5

Scheduler and configuration controller for the Pc=5 QC-LDPC shift network (QSN: left shifter, right shifter, merge stage). It arbitrates two message requesters (VNU side, CNU side) for the single shared QSN instance with round-robin fairness. Each accepted shift factor is turned into per-stage select words, issued in step with the QSN's registered stages. The block also returns a tagged completion pulse when the routed message leaves the merge stage.

## Interface
- TAG_W, 4, width of requester tag carried through to completion
- sys_clk  in  1  clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- en  in  1  scheduler enable; low blocks new grants, pipeline drains
- req_valid  in  2  per-requester request valid (bit0 = VNU, bit1 = CNU)
- req_shift0 / req_shift1  in  3 each  shift factor, legal 0..4
- req_tag0 / req_tag1  in  TAG_W each  opaque tag
- req_ready  out  2  one-hot grant, combinational
- msg_load  out  1  loads granted message into QSN input register (accept cycle)
- msg_src  out  1  requester index for the data mux (valid with msg_load)
- left_sel  out  3  left-shifter select
- right_sel  out  3  right-shifter select
- merge_sel  out  4  merge select, bit i = 1 takes left_in[i], else right_in[4-i]
- out_valid  out  1  completion pulse
- out_tag  out  TAG_W  tag of completed message
- out_src  out  1  requester of completed message
- err_shift  out  1  sticky illegal-shift flag
- err_src  out  1  requester that raised the latest error
- err_clr  in  1  clears err_shift

## Operation
- Arbitration: round-robin pointer rr (reset 0). If en and both valid: grant rr, then rr <= ~rr. If only one valid: grant it, rr <= ~granted. req_ready = grant; at most one bit high; zero when en = 0.
- Accept = req_valid[i] & req_ready[i]; msg_load = accept and shift legal; msg_src = i.
- Select decode, shift s in 0..4: left_sel = s; right_sel = (s == 0) ? 0 : 5 - s; merge_sel = 4'hF >> s (s=0 -> 1111, s=1 -> 0111, s=4 -> 0000).
- Illegal s (5..7): request is consumed (ready asserted, handshake completes), nothing enters pipeline, err_shift <= 1, err_src <= i. err_clr and new error in same cycle: set wins.
- Select registers update only when a valid entry advances into their stage; otherwise hold last value.
- No downstream backpressure; one new message per cycle sustained.

## Timing
- Accept in cycle T (combinational grant).
- T+1: left_sel, right_sel registered; stage-1 valid.
- T+2: merge_sel registered; stage-2 valid, tag/src delayed alongside.
- T+3: out_valid = 1 for one cycle with out_tag, out_src. Fixed latency 3.
- Back-to-back accepts produce back-to-back out_valid pulses, order preserved.
- Reset values: req_ready 0, msg_load 0, msg_src 0, left_sel 0, right_sel 0, merge_sel 4'hF, out_valid 0, out_tag 0, out_src 0, err_shift 0, err_src 0, rr 0.
- rstn asserted mid-flight: all stage valids cleared immediately; in-flight messages dropped, no completion pulse.
- en falls: no grant that cycle; entries already accepted still complete at T+3.

## Test plan
- Single VNU request, s=2, tag 0x5 -> ready=01 same cycle; T+1 left_sel=2, right_sel=3; T+2 merge_sel=0011; T+3 out_valid, out_tag=0x5, out_src=0.
- Both valid continuously for 4 cycles after reset -> grants 0,1,0,1; four consecutive out_valid with src 0,1,0,1.
- Sweep s=0..4 on requester 1 -> merge_sel 1111,0111,0011,0001,0000; right_sel 0,4,3,2,1.
- s=6 on requester 0 -> ready=01, msg_load=0, no out_valid, err_shift=1, err_src=0; err_clr with simultaneous second illegal request -> err_shift stays 1.
- en=0 with both valid -> req_ready=00; in-flight entry still completes at T+3.
- rstn low at T+1 of an accepted message -> no out_valid at T+3; all outputs at reset values, merge_sel=1111.
